// File: rtl/alu_exec_if.sv
// alu_exec_if: EX-stage operand/result handshake bundle for alu_exec_unit.
// master = issuing pipeline stage, slave = execution unit.
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            ready_o;
    logic [1:0]      ALUOp_i;
    logic [9:0]      funct_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic            err_o;
    modport master (
        output valid_i, ALUOp_i, funct_i, rs1_i, rs2_i, flush_i,
        input  ready_o, valid_o, result_o, err_o
    );
    modport slave (
        input  valid_i, ALUOp_i, funct_i, rs1_i, rs2_i, flush_i,
        output ready_o, valid_o, result_o, err_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decode + execute + register for RV32I ALU ops, fixed-latency MUL,
// iterative restoring DIV/REM (only when ALU_EXEC_DIV_EN is defined).
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    alu_exec_if.slave  bus
);
    localparam int SW   = $clog2(XLEN);
    localparam int CMAX = (MUL_LAT > XLEN) ? MUL_LAT : XLEN;
    localparam int CW   = $clog2(CMAX + 1) + 1;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_e;
`ifdef ALU_EXEC_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_e;
`endif
    function automatic op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction
`ifdef ALU_EXEC_DIV_EN
    function automatic op_e md_op(input logic [1:0] f);
        case (f)
            2'b00:   return OP_DIV;
            2'b01:   return OP_DIVU;
            2'b10:   return OP_REM;
            default: return OP_REMU;
        endcase
    endfunction
`endif
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    op_e             op;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] a, b, res, prod;
    logic [SW-1:0]   sh;
    logic            rdy, accept, go_mul;
    assign f7     = bus.funct_i[9:3];
    assign f3     = bus.funct_i[2:0];
    assign a      = bus.rs1_i;
    assign b      = bus.rs2_i;
    assign sh     = b[SW-1:0];
    assign prod   = a * b;
    assign rdy    = (state_q == S_IDLE);
    assign accept = bus.valid_i & rdy & ~bus.flush_i;
    assign go_mul = accept & (op == OP_MUL) & (MUL_LAT > 1);
    always_comb begin
        op = OP_ILL;
        case (bus.ALUOp_i)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                if (f7 == 7'b0000000)
                    op = base_op(f3);
                else if (f7 == 7'b0100000)
                    op = (f3 == 3'b000) ? OP_SUB : (f3 == 3'b101) ? OP_SRA : OP_ILL;
                else if (f7 == 7'b0000001)
`ifdef ALU_EXEC_DIV_EN
                    op = (f3 == 3'b000) ? OP_MUL : f3[2] ? md_op(f3[1:0]) : OP_ILL;
`else
                    op = (f3 == 3'b000) ? OP_MUL : OP_ILL;
`endif
            end
            // I-type: funct7 carries immediate bits, only bit 30 is meaningful
            default: op = (f3 == 3'b001 && bus.funct_i[8]) ? OP_ILL :
                          (f3 == 3'b101 && bus.funct_i[8]) ? OP_SRA : base_op(f3);
        endcase
    end
    always_comb begin
        case (op)
            OP_ADD:           res = a + b;
            OP_SUB:           res = a - b;
            OP_SLL:           res = a << sh;
            OP_SLT:           res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:          res = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:           res = a ^ b;
            OP_SRL:           res = a >> sh;
            OP_SRA:           res = $unsigned($signed(a) >>> sh);
            OP_OR:            res = a | b;
            OP_AND:           res = a & b;
            OP_MUL:           res = prod;
            OP_DIV, OP_DIVU:  res = '1;
            OP_REM, OP_REMU:  res = a;
            default:          res = '0;
        endcase
    end
`ifdef ALU_EXEC_DIV_EN
    logic [XLEN-1:0] rem_q, rem_d, dvs_q, dvs_d, abs_a, abs_b, fin;
    logic            neg_q, neg_d, isrem_q, isrem_d;
    logic            is_div, sgn, a_neg, b_neg, go_div;
    logic [XLEN:0]   rem_sh, diff;
    assign is_div = (op == OP_DIV) | (op == OP_DIVU) | (op == OP_REM) | (op == OP_REMU);
    assign sgn    = (op == OP_DIV) | (op == OP_REM);
    assign a_neg  = sgn & a[XLEN-1];
    assign b_neg  = sgn & b[XLEN-1];
    assign abs_a  = a_neg ? -a : a;
    assign abs_b  = b_neg ? -b : b;
    // division by zero takes the single-cycle path through res
    assign go_div = accept & is_div & (b != '0);
    assign rem_sh = {rem_q, acc_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign fin    = isrem_q ? rem_q : acc_q;
`endif
    always_comb begin
        state_d = state_q;
        if (bus.flush_i)
            state_d = S_IDLE;
        else
            case (state_q)
`ifdef ALU_EXEC_DIV_EN
                S_IDLE:  state_d = go_mul ? S_MUL : go_div ? S_DIV : S_IDLE;
                S_DIV:   state_d = (cnt_q == '0) ? S_IDLE : S_DIV;
`else
                S_IDLE:  state_d = go_mul ? S_MUL : S_IDLE;
`endif
                S_MUL:   state_d = (cnt_q == CW'(1)) ? S_IDLE : S_MUL;
                default: state_d = S_IDLE;
            endcase
    end
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        valid_d  = 1'b0;
        result_d = result_q;
        err_d    = err_q;
`ifdef ALU_EXEC_DIV_EN
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        isrem_d  = isrem_q;
`endif
        if (!bus.flush_i)
            case (state_q)
                S_IDLE: begin
                    if (go_mul) begin
                        acc_d = prod;
                        cnt_d = CW'(MUL_LAT - 1);
                    end
`ifdef ALU_EXEC_DIV_EN
                    else if (go_div) begin
                        acc_d   = abs_a;
                        dvs_d   = abs_b;
                        rem_d   = '0;
                        cnt_d   = CW'(XLEN);
                        isrem_d = (op == OP_REM) | (op == OP_REMU);
                        neg_d   = isrem_d ? a_neg : a_neg ^ b_neg;
                    end
`endif
                    else if (accept) begin
                        valid_d  = 1'b1;
                        err_d    = (op == OP_ILL);
                        result_d = res;
                    end
                end
                S_MUL: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        valid_d  = 1'b1;
                        err_d    = 1'b0;
                        result_d = acc_q;
                    end
                end
`ifdef ALU_EXEC_DIV_EN
                // acc_q shifts dividend bits out and quotient bits in
                S_DIV: begin
                    if (cnt_q != '0) begin
                        acc_d = {acc_q[XLEN-2:0], ~diff[XLEN]};
                        rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        valid_d  = 1'b1;
                        err_d    = 1'b0;
                        result_d = neg_q ? -fin : fin;
                    end
                end
`endif
                default: ;
            endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            isrem_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef ALU_EXEC_DIV_EN
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            neg_q    <= neg_d;
            isrem_q  <= isrem_d;
`endif
        end
    end
    assign bus.ready_o  = rdy;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.err_o    = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit (XLEN=32, MUL_LAT=2);
// DIV expectations follow ALU_EXEC_DIV_EN.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_chk = 0;
    always #5 clk = ~clk;
    alu_exec_if #(.XLEN(32)) bus ();
    alu_exec_unit #(.XLEN(32), .MUL_LAT(2)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );
    localparam logic [6:0] F0 = 7'b0000000;
    localparam logic [6:0] FA = 7'b0100000;
    localparam logic [6:0] FM = 7'b0000001;
    function automatic logic [9:0] fn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, f3};
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic drive(input logic [1:0] op, input logic [9:0] f, input logic [31:0] x, input logic [31:0] y);
        bus.valid_i = 1'b1;
        bus.ALUOp_i = op;
        bus.funct_i = f;
        bus.rs1_i   = x;
        bus.rs2_i   = y;
    endtask
    task automatic issue(input logic [1:0] op, input logic [9:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        drive(op, f, x, y);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask
    task automatic single(input string tag, input logic [1:0] op, input logic [9:0] f,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input logic exp_err);
        issue(op, f, x, y);
        check({tag, ".valid"}, bus.valid_o, 1);
        check(tag, bus.result_o, exp);
        check({tag, ".err"}, bus.err_o, exp_err);
    endtask
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus.valid_o && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask
    task automatic multi(input string tag, input logic [1:0] op, input logic [9:0] f,
                         input logic [31:0] x, input logic [31:0] y,
                         input int exp_lat, input logic [31:0] exp);
        int c;
        issue(op, f, x, y);
        wait_valid(c);
        check({tag, ".lat"}, c, exp_lat);
        check(tag, bus.result_o, exp);
        check({tag, ".err"}, bus.err_o, 0);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ALUOp_i = 2'b00;
        bus.funct_i = '0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", bus.ready_o, 1);
        check("rst.valid", bus.valid_o, 0);
        check("rst.result", bus.result_o, 0);
        check("rst.err", bus.err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        single("add",      2'b00, fn(F0, 3'd0), 32'd5, 32'd7, 32'd12, 1'b0);
        single("sub",      2'b01, fn(F0, 3'd0), 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
        single("sra_r",    2'b10, fn(FA, 3'd5), 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
        single("srl_r",    2'b10, fn(F0, 3'd5), 32'h80000000, 32'd4, 32'h08000000, 1'b0);
        single("slt",      2'b10, fn(F0, 3'd2), 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        single("sltu",     2'b10, fn(F0, 3'd3), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        single("sll",      2'b10, fn(F0, 3'd1), 32'd1, 32'h21, 32'd2, 1'b0);
        single("xor",      2'b10, fn(F0, 3'd4), 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0);
        single("or",       2'b10, fn(F0, 3'd6), 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0);
        single("and",      2'b10, fn(F0, 3'd7), 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
        single("sub_r",    2'b10, fn(FA, 3'd0), 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
        single("srai",     2'b11, fn(FA, 3'd5), 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
        single("addi_f7",  2'b11, fn(FA, 3'd0), 32'd5, 32'd7, 32'd12, 1'b0);
        single("slli_bad", 2'b11, fn(FA, 3'd1), 32'd1, 32'd1, 32'd0, 1'b1);
        single("bad_f7",   2'b10, fn(7'b0000010, 3'd0), 32'd5, 32'd7, 32'd0, 1'b1);
        single("add_ok",   2'b00, fn(F0, 3'd0), 32'd5, 32'd7, 32'd12, 1'b0);
        issue(2'b10, fn(FM, 3'd0), 32'hFFFFFFFD, 32'd7);
        check("mul.c1.ready", bus.ready_o, 0);
        check("mul.c1.valid", bus.valid_o, 0);
        @(posedge clk);
        #1;
        check("mul.c2.valid", bus.valid_o, 1);
        check("mul.c2.ready", bus.ready_o, 1);
        check("mul", bus.result_o, 32'hFFFFFFEB);
        check("mul.err", bus.err_o, 0);
        @(negedge clk);
        drive(2'b00, fn(F0, 3'd0), 32'd1, 32'd2);
        @(posedge clk);
        #1;
        check("b2b1.valid", bus.valid_o, 1);
        check("b2b1", bus.result_o, 32'd3);
        drive(2'b01, fn(F0, 3'd0), 32'd10, 32'd4);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        check("b2b2.valid", bus.valid_o, 1);
        check("b2b2", bus.result_o, 32'd6);
        issue(2'b10, fn(FM, 3'd0), 32'd3, 32'd3);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("mflush.valid", bus.valid_o, 0);
        check("mflush.ready", bus.ready_o, 1);
        check("mflush.result", bus.result_o, 32'd6);
        @(posedge clk);
        #1;
        check("mflush.c2.valid", bus.valid_o, 0);
        @(negedge clk);
        drive(2'b00, fn(F0, 3'd0), 32'd1, 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("iflush.valid", bus.valid_o, 0);
        check("iflush.result", bus.result_o, 32'd6);
        single("add_post", 2'b00, fn(F0, 3'd0), 32'd2, 32'd2, 32'd4, 1'b0);
`ifdef ALU_EXEC_DIV_EN
        multi("div",    2'b10, fn(FM, 3'd4), 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD);
        multi("rem",    2'b10, fn(FM, 3'd6), 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF);
        multi("divu",   2'b10, fn(FM, 3'd5), 32'd100, 32'd7, 34, 32'd14);
        multi("remu",   2'b10, fn(FM, 3'd7), 32'd100, 32'd7, 34, 32'd2);
        multi("div_ov", 2'b10, fn(FM, 3'd4), 32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000);
        multi("rem_ov", 2'b10, fn(FM, 3'd6), 32'h80000000, 32'hFFFFFFFF, 34, 32'd0);
        single("divu0", 2'b10, fn(FM, 3'd5), 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0);
        single("rem0",  2'b10, fn(FM, 3'd6), 32'h1234, 32'd0, 32'h1234, 1'b0);
        begin
            int seen;
            issue(2'b10, fn(FM, 3'd4), 32'd100, 32'd7);
            repeat (9) @(posedge clk);
            #1;
            bus.flush_i = 1'b1;
            @(posedge clk);
            #1;
            bus.flush_i = 1'b0;
            check("dflush.ready", bus.ready_o, 1);
            check("dflush.valid", bus.valid_o, 0);
            seen = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (bus.valid_o) seen++;
            end
            check("dflush.spurious", seen, 0);
            check("dflush.result", bus.result_o, 32'h1234);
        end
        single("add_postdiv", 2'b00, fn(F0, 3'd0), 32'd20, 32'd22, 32'd42, 1'b0);
`else
        single("div_off",  2'b10, fn(FM, 3'd4), 32'hFFFFFFF9, 32'd2, 32'd0, 1'b1);
        single("remu_off", 2'b10, fn(FM, 3'd7), 32'd100, 32'd7, 32'd0, 1'b1);
        single("add_postdiv", 2'b00, fn(F0, 3'd0), 32'd20, 32'd22, 32'd42, 1'b0);
`endif
        issue(2'b10, fn(FM, 3'd0), 32'd5, 32'd5);
        rst_n = 1'b0;
        #1;
        check("arst.ready", bus.ready_o, 1);
        check("arst.valid", bus.valid_o, 0);
        check("arst.result", bus.result_o, 0);
        check("arst.err", bus.err_o, 0);
        @(posedge clk);
        #1;
        check("arst.c2.valid", bus.valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        single("add_postrst", 2'b00, fn(F0, 3'd0), 32'd1, 32'd1, 32'd2, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
